// File: rtl/ovl_next_pkg.sv
// Shared encodings for the multi-channel "next" checker: violation cause codes,
// mode bit positions and the cause priority encoder.
package ovl_next_pkg;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_NEXT = 2'b01;
    localparam logic [1:0] CAUSE_OVLP = 2'b10;
    localparam logic [1:0] CAUSE_MISS = 2'b11;

    localparam int MODE_ALLOW_OVLP = 0;
    localparam int MODE_CHK_MISS   = 1;

    // Next-miss outranks overlap, which outranks missing-start.
    function automatic logic [1:0] cause_select(input logic next_miss,
                                                input logic ovlp,
                                                input logic miss_start);
        logic [1:0] c;
        if (next_miss) begin
            c = CAUSE_NEXT;
        end else if (ovlp) begin
            c = CAUSE_OVLP;
        end else if (miss_start) begin
            c = CAUSE_MISS;
        end else begin
            c = CAUSE_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/ovl_next_chan.sv
// One checker channel: start history shift register plus the combinational
// next-miss / overlap / missing-start detection for that channel.
module ovl_next_chan
    import ovl_next_pkg::*;
#(
    parameter int NUM_CKS_MAX = 7,
    parameter int NUM_CKS_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 chk_en,
    input  logic                 hist_clr,
    input  logic [NUM_CKS_W-1:0] num_cks,
    input  logic [1:0]           mode,
    input  logic                 start,
    input  logic                 test,
    output logic                 fire_comb,
    output logic [1:0]           cause
);

    // p_q[i] set means a start was seen i+1 enabled cycles ago
    logic [NUM_CKS_MAX-1:0] p_q;
    logic [NUM_CKS_MAX-1:0] p_d;
    logic                   due;
    logic                   outstanding;
    logic                   next_miss;
    logic                   ovlp;
    logic                   miss_start;

    // Select the due bit and OR the younger history bits; bits beyond num_cks are ignored
    always_comb begin
        due         = 1'b0;
        outstanding = 1'b0;
        for (int i = 0; i < NUM_CKS_MAX; i++) begin
            if (i == int'(num_cks) - 1) begin
                due = p_q[i];
            end else begin
                due = due;
            end
            if (i < int'(num_cks) - 1) begin
                outstanding = outstanding | p_q[i];
            end else begin
                outstanding = outstanding;
            end
        end
    end

    // Violation detection, cause encoding and history next state
    always_comb begin
        next_miss  = due & ~test;
        ovlp       = start & ~mode[MODE_ALLOW_OVLP] & outstanding;
        miss_start = mode[MODE_CHK_MISS] & test & ~due;
        if (chk_en) begin
            cause = cause_select(next_miss, ovlp, miss_start);
        end else begin
            cause = CAUSE_NONE;
        end
        fire_comb = (cause != CAUSE_NONE);
        if (hist_clr) begin
            p_d = {NUM_CKS_MAX{1'b0}};
        end else if (enable) begin
            p_d = {p_q[NUM_CKS_MAX-2:0], start};
        end else begin
            p_d = p_q;
        end
    end

    // History register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= {NUM_CKS_MAX{1'b0}};
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/ovl_next_multi.sv
// Multi-channel "next" checker: config shadow with change masking, per-channel
// checkers, registered fire/cause, sticky status, saturating error counter and
// the prevConfigInvalid-gated summary output.
module ovl_next_multi
    import ovl_next_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int NUM_CKS_MAX = 7,
    parameter int NUM_CKS_W   = 3,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_CKS_W-1:0] num_cks,
    input  logic [1:0]           mode,
    input  logic [N_CH-1:0]      start_event,
    input  logic [N_CH-1:0]      test_expr,
    input  logic                 prevConfigInvalid,
    input  logic                 clr_sticky,
    output logic [N_CH-1:0]      fire_comb,
    output logic [N_CH-1:0]      fire,
    output logic [2*N_CH-1:0]    fire_cause,
    output logic [N_CH-1:0]      err_sticky,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 cfg_err,
    output logic                 out
);

    logic [NUM_CKS_W-1:0] num_cks_q;
    logic [1:0]           mode_q;
    logic [N_CH-1:0]      fire_q;
    logic [2*N_CH-1:0]    cause_q;
    logic [N_CH-1:0]      sticky_q;
    logic [N_CH-1:0]      sticky_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 cfg_err_q;
    logic [2*N_CH-1:0]    cause_comb;
    logic                 cfg_valid;
    logic                 cfg_chg;
    logic                 chk_en;
    logic                 hist_clr;
    logic                 any_fire;

    // Config validity, change detection and channel gating
    always_comb begin
        cfg_valid = (num_cks != {NUM_CKS_W{1'b0}}) && (int'(num_cks) <= NUM_CKS_MAX);
        cfg_chg   = (num_cks != num_cks_q) || (mode != mode_q);
        chk_en    = enable & cfg_valid & ~cfg_chg & ~rst;
        hist_clr  = ~cfg_valid | cfg_chg;
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
        ovl_next_chan #(
            .NUM_CKS_MAX (NUM_CKS_MAX),
            .NUM_CKS_W   (NUM_CKS_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .chk_en    (chk_en),
            .hist_clr  (hist_clr),
            .num_cks   (num_cks),
            .mode      (mode),
            .start     (start_event[ch]),
            .test      (test_expr[ch]),
            .fire_comb (fire_comb[ch]),
            .cause     (cause_comb[2*ch +: 2])
        );
    end

    // Sticky and counter next state; a fire coinciding with a clear survives it
    always_comb begin
        any_fire = |fire_comb;
        if (clr_sticky) begin
            sticky_d = fire_comb;
            cnt_d    = any_fire ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else begin
            sticky_d = sticky_q | fire_comb;
            if (any_fire && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Status, config shadow and registered fire/cause
    always_ff @(posedge clk) begin
        if (rst) begin
            num_cks_q <= {NUM_CKS_W{1'b0}};
            mode_q    <= 2'b00;
            fire_q    <= {N_CH{1'b0}};
            cause_q   <= {(2*N_CH){1'b0}};
            sticky_q  <= {N_CH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            num_cks_q <= num_cks;
            mode_q    <= mode;
            fire_q    <= fire_comb;
            cause_q   <= cause_comb;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= ~cfg_valid;
        end
    end

    assign fire       = fire_q;
    assign fire_cause = cause_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign cfg_err    = cfg_err_q;
    assign out        = any_fire & ~prevConfigInvalid;

endmodule

// File: doc/ovl_next_multi.md
Name: ovl_next_multi

Overview:
- Parametrised multi-channel successor to the single-channel "next" OVL checker used in the fabric monitor path.
- Each channel checks that test_expr is asserted exactly num_cks cycles after start_event.
- Runtime mode bits add an overlap check and a missing-start check.
- Adds per-channel registered/sticky status, a saturating error counter and config-change masking, and keeps the prevConfigInvalid-gated single-bit out used by the fabric.

Parameters:
- N_CH, 4, number of independent checker channels (1..16)
- NUM_CKS_MAX, 7, maximum programmable check distance in cycles (2..64)
- NUM_CKS_W, 3, width of num_cks; must satisfy 2**NUM_CKS_W > NUM_CKS_MAX
- CNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  global check enable
- num_cks  in  NUM_CKS_W  check distance, shared by all channels
- mode  in  2  bit0 allow_overlap, bit1 check_missing_start
- start_event  in  N_CH  per-channel start
- test_expr  in  N_CH  per-channel expected event
- prevConfigInvalid  in  1  masks out when high
- clr_sticky  in  1  clears err_sticky and err_cnt
- fire_comb  out  N_CH  combinational per-channel violation
- fire  out  N_CH  fire_comb registered, one cycle later
- fire_cause  out  2*N_CH  registered cause per channel: 01 next-miss, 10 overlap, 11 missing-start, 00 none
- err_sticky  out  N_CH  sticky OR of fire
- err_cnt  out  CNT_W  saturating count of cycles with any fire_comb bit set
- cfg_err  out  1  registered; high while num_cks==0 or num_cks>NUM_CKS_MAX
- out  out  1  |fire_comb & ~prevConfigInvalid (combinational)

Behaviour:
- Reset (sync, rst=1): pend vectors, fire, fire_cause, err_sticky, err_cnt, cfg_err and the config shadow registers are all 0. fire_comb and out are 0 during reset.
- Per-channel pend vector p[NUM_CKS_MAX-1:0]. On a clock edge with enable=1 and cfg valid: p <= {p[MAX-2:0], start_event[ch]}. p[i] means a start occurred i+1 enabled cycles ago.
- due = p[num_cks-1]. outstanding = |p[num_cks-2:0]; outstanding is 0 when num_cks==1.
- next-miss = due & ~test_expr.
- overlap = start_event & ~allow_overlap & outstanding. If start and due coincide, that is not an overlap.
- missing-start = check_missing_start & test_expr & ~due.
- fire_comb[ch] = enable & cfg_valid & ~cfg_chg & (next-miss | overlap | missing-start).
- Cause priority: next-miss > overlap > missing-start.
- Bits of p at index >= num_cks are ignored.
- enable=0: p holds, fire_comb=0, counters hold.
- Invalid config (num_cks==0 or num_cks>NUM_CKS_MAX):
  - cfg_err=1 the next cycle.
  - p is cleared.
  - fire_comb=0.
- Config change (cfg_chg): num_cks or mode differs from the registered shadow.
  - That cycle: p is cleared and fire_comb is masked.
  - Shadow updates; checking resumes the next cycle with empty history.
- fire and fire_cause are registered copies of fire_comb and its cause (latency 1).
- err_sticky |= fire_comb.
- err_cnt increments when |fire_comb is set and saturates at all-ones.
- clr_sticky zeroes err_sticky and err_cnt. If clr_sticky coincides with a new fire, the new fire wins: sticky bit set, count = 1.
- Channels are fully independent except for the shared num_cks, mode and enable.

Decomposition:
- Package ovl_next_pkg holds:
  - cause encoding constants CAUSE_NONE/NEXT/OVLP/MISS
  - mode bit index constants
- One sub-module, ovl_next_chan: pend shift register plus per-channel cause logic, instantiated N_CH times by a generate loop.
- Top level holds:
  - config shadow and cfg_chg/cfg_err logic
  - sticky/counter logic
  - out gating

Test Plan:
1. num_cks=3, mode=00. Start ch0 at cycle 10, test_expr ch0 at cycle 13 -> no fire. Repeat with test_expr absent at 13 -> fire_comb[0]=1 at 13, fire[0]=1 and cause=01 at 14, err_cnt=1.
2. num_cks=4, mode=00. Starts at 10 and 12 -> overlap at 12 (cause 10). With mode=01, same stimulus -> no overlap; test_expr at 14 and 16 passes.
3. num_cks=2, mode=10. test_expr at cycle 20 with no start at 18 -> cause 11. Start at 18 plus test at 20 -> clean.
4. num_cks changed 3->5 while a start is pending -> fire_comb masked that cycle, pend cleared, no later miss. num_cks=0 -> cfg_err=1 next cycle, no fires.
5. prevConfigInvalid=1 during a ch2 miss -> out=0 while fire_comb[2]=1. With enable=0 across the due cycle, the check is deferred until enable returns.
6. 300 consecutive miss cycles, CNT_W=8 -> err_cnt=255. clr_sticky with a simultaneous fire -> err_cnt=1, sticky set. Mid-run rst -> all outputs 0 the next cycle.
